bcd_converter_seq: RTL

- Sequential, parametrised binary-to-BCD converter feeding the 4-digit 7-segment output path (registerOUT → BCD digits → displayBcd).
- Replaces the fixed combinational 32-bit/4-digit conversion with a double-dabble engine.
- Adds generic width and digit count, signed mode, a start/busy/done handshake, and overflow detection with saturation.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_adjust_digit.sv | 17 +
 rtl/bcd_converter_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned NIBBLE   = 4;
  localparam logic [3:0]  BCD_NINE = 4'd9;

  // Counter width able to hold the value data_w (shift count loaded on start).
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/bcd_adjust_digit.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before a shift.
module bcd_adjust_digit
  import bcd_pkg::*;
(
  input  logic [NIBBLE-1:0] digit,
  output logic [NIBBLE-1:0] adj_c
);

  // Combinational +3 correction.
  always_comb begin
    adj_c = digit;
    if (digit >= NIBBLE'(5)) begin
      adj_c = digit + NIBBLE'(3);
    end
  end

endmodule

// File: rtl/bcd_converter_seq.sv
// Sequential double-dabble binary-to-BCD converter with signed mode,
// start/busy/done handshake and saturating overflow detection.
module bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DIGITS    = 4,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     signed_mode,
  output logic                     busy,
  output logic                     done,
  output logic [NIBBLE*DIGITS-1:0] digits,
  output logic                     negative,
  output logic                     overflow
);

  localparam int unsigned BCD_W = NIBBLE * DIGITS;
  localparam int unsigned CNT_W = cnt_width(DATA_W);

  state_t             state_q;
  state_t             state_d;
  logic [DATA_W-1:0]  mag_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   adj_c;
  logic               load_c;
  logic               shift_c;
  logic               commit_c;
  logic               busy_d;
  logic               neg_in_c;
  logic [DATA_W-1:0]  mag_in_c;
  logic [BCD_W-1:0]   nines_c;
  logic               result_zero_c;

  // One +3 corrector per BCD digit of the scratch register.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adjust
    bcd_adjust_digit u_adjust (
      .digit (scratch_q[g*NIBBLE +: NIBBLE]),
      .adj_c (adj_c[g*NIBBLE +: NIBBLE])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SHIFT for DATA_W edges -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state control strobes and next busy value.
  always_comb begin
    load_c   = 1'b0;
    shift_c  = 1'b0;
    commit_c = 1'b0;
    unique case (state_q)
      IDLE:    load_c   = start;
      SHIFT:   shift_c  = 1'b1;
      DONE:    commit_c = 1'b1;
      default: ;
    endcase
    busy_d = (state_d == SHIFT);
  end

  // Operand magnitude/sign extraction and result helpers.
  always_comb begin
    neg_in_c      = signed_mode & SIGNED_EN & data_in[DATA_W-1];
    mag_in_c      = neg_in_c ? DATA_W'(~data_in + DATA_W'(1)) : data_in;
    nines_c       = {DIGITS{BCD_NINE}};
    result_zero_c = (scratch_q == '0) && !ovf_q;
  end

  // Conversion datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      digits    <= '0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= commit_c;
      if (load_c) begin
        mag_q     <= mag_in_c;
        neg_q     <= neg_in_c;
        scratch_q <= '0;
        ovf_q     <= 1'b0;
        cnt_q     <= CNT_W'(DATA_W);
      end
      if (shift_c) begin
        scratch_q <= {adj_c[BCD_W-2:0], mag_q[DATA_W-1]};
        mag_q     <= {mag_q[DATA_W-2:0], 1'b0};
        cnt_q     <= cnt_q - CNT_W'(1);
        if (adj_c[BCD_W-1]) begin
          ovf_q <= 1'b1;
        end
      end
      if (commit_c) begin
        digits   <= ovf_q ? nines_c : scratch_q;
        negative <= neg_q & ~result_zero_c;
        overflow <= ovf_q;
      end
    end
  end

endmodule
